fft_bitrev_reorder: RTL and testbench

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_bitrev_reorder_if.sv | 28 ++
 rtl/fft_bitrev_bank.sv | 33 +++
 rtl/fft_bitrev_reorder.sv | 101 ++++++++++
 tb/tb_fft_bitrev_reorder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT bit-reverse reorder block.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package fft_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

  // Reverse the low nbits bits of value; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) begin
        r[i] = value[nbits-1-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle for the reorder block: bit-reversed input side and natural-order output side.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on each side; slave is the reorder block, master is the environment.
interface fft_bitrev_reorder_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_re;
  logic [DATA_WIDTH-1:0] in_im;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_re;
  logic [DATA_WIDTH-1:0] out_im;
  logic                  out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );

endinterface

// File: rtl/fft_bitrev_bank.sv
// One frame of complex sample storage: registered write port, combinational read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the owner decides when to write.
module fft_bitrev_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16,
  localparam int AW        = $clog2(N_POINTS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wre,
  input  logic [DATA_WIDTH-1:0] wim,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rre,
  output logic [DATA_WIDTH-1:0] rim
);

  logic [DATA_WIDTH-1:0] mem_re [N_POINTS];
  logic [DATA_WIDTH-1:0] mem_im [N_POINTS];

  // Contents are never reset; the bank state in the owner decides validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_re[waddr] <= wre;
      mem_im[waddr] <= wim;
    end
  end

  assign rre = mem_re[raddr];
  assign rim = mem_im[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder of bit-reversed FFT output frames into natural bin order.
// Latency: first output valid the cycle after the last sample of a frame is accepted.
// Backpressure: in_ready drops when the write bank is still full; out side holds data while out_ready=0.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16
) (
  input logic                  clk,
  input logic                  rst,
  fft_bitrev_reorder_if.slave  bus
);

  localparam int            AW       = $clog2(N_POINTS);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);

  bank_state_t           bank_state [2];
  logic [AW-1:0]         wr_cnt;
  logic [AW-1:0]         rd_cnt;
  logic                  wr_sel;
  logic                  rd_sel;
  logic                  accept;
  logic                  xfer;
  logic                  wr_done;
  logic                  rd_done;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] rd_re [2];
  logic [DATA_WIDTH-1:0] rd_im [2];

  // Handshakes are gated by rst so nothing is offered or accepted while reset is held.
  assign bus.in_ready  = rst && (bank_state[wr_sel] == BANK_EMPTY);
  assign bus.out_valid = rst && (bank_state[rd_sel] == BANK_FULL);
  assign accept        = bus.in_valid && bus.in_ready;
  assign xfer          = bus.out_valid && bus.out_ready;
  assign wr_done       = accept && (wr_cnt == LAST_IDX);
  assign rd_done       = xfer && (rd_cnt == LAST_IDX);

  // Scatter on write so the read side simply walks addresses in order.
  assign wr_addr = AW'(bitrev(32'(wr_cnt), AW));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_bitrev_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .N_POINTS   (N_POINTS)
    ) u_bank (
      .clk   (clk),
      .we    (accept && (wr_sel == 1'(b))),
      .waddr (wr_addr),
      .wre   (bus.in_re),
      .wim   (bus.in_im),
      .raddr (rd_cnt),
      .rre   (rd_re[b]),
      .rim   (rd_im[b])
    );
  end

  assign bus.out_re   = bus.out_valid ? rd_re[rd_sel] : '0;
  assign bus.out_im   = bus.out_valid ? rd_im[rd_sel] : '0;
  assign bus.out_last = bus.out_valid && (rd_cnt == LAST_IDX);

  // Write-side counter and bank select advance on accepted samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt <= '0;
      wr_sel <= 1'b0;
    end else if (accept) begin
      wr_cnt <= wr_done ? '0 : wr_cnt + 1'b1;
      if (wr_done) begin
        wr_sel <= ~wr_sel;
      end
    end
  end

  // Read-side counter and bank select advance on transferred samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_cnt <= '0;
      rd_sel <= 1'b0;
    end else if (xfer) begin
      rd_cnt <= rd_done ? '0 : rd_cnt + 1'b1;
      if (rd_done) begin
        rd_sel <= ~rd_sel;
      end
    end
  end

  // Bank states: a fill and a drain on the same edge always hit different banks, so both apply.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!rst) begin
        bank_state[b] <= BANK_EMPTY;
      end else if (wr_done && (wr_sel == 1'(b))) begin
        bank_state[b] <= BANK_FULL;
      end else if (rd_done && (rd_sel == 1'(b))) begin
        bank_state[b] <= BANK_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for the bit-reverse reorder block (16 points, 16-bit parts).
// Latency: n/a.
// Backpressure: exercises full-bank stall, random stalls and mid-frame reset.
module tb_fft_bitrev_reorder;

  localparam int DW = 16;
  localparam int NP = 16;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.DATA_WIDTH(DW)) bus ();

  fft_bitrev_reorder #(
    .DATA_WIDTH (DW),
    .N_POINTS   (NP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t          sb [$];
  logic [2*DW-1:0] frame_buf [NP];
  int            wcnt      = 0;
  int            checks    = 0;
  int            errors    = 0;
  int            stall_cnt = 0;
  logic          rnd_done  = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rev4(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      r = (r << 1) | ((k >> i) & 1);
    end
    return r;
  endfunction

  // Scoreboard: record accepted inputs, push a reordered frame once complete, compare on transfer.
  always @(negedge clk) begin
    if (!rst) begin
      wcnt = 0;
      sb.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        frame_buf[wcnt] = {bus.in_re, bus.in_im};
        wcnt++;
        if (wcnt == NP) begin
          for (int j = 0; j < NP; j++) begin
            sb.push_back({frame_buf[rev4(j)], 1'(j == NP - 1)});
          end
          wcnt = 0;
        end
      end
      if (!bus.out_valid) begin
        check_val("idle_outputs_zero", 64'({bus.out_last, bus.out_re, bus.out_im}), 64'd0);
      end else if (bus.out_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_output", 64'({bus.out_re, bus.out_im}), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("out_re", 64'(bus.out_re), 64'(e.re));
          check_val("out_im", 64'(bus.out_im), 64'(e.im));
          check_val("out_last", 64'(bus.out_last), 64'(e.last));
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_re    = re;
    bus.in_im    = im;
    @(negedge clk);
    while (!bus.in_ready && t < 500) begin
      stall_cnt++;
      t++;
      @(negedge clk);
    end
    if (t >= 500) check_val("send_timeout", 64'(t), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.out_ready = 1'b1;
    while ((sb.size() != 0 || bus.out_valid) && t < 400) begin
      @(posedge clk);
      #2;
      t++;
    end
    check_val("drain_in_time", 64'(t < 400), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_out_data", 64'({bus.out_last, bus.out_re, bus.out_im}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single frame: re=k, im=-k, with latency check on the 16th sample
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < NP - 1; k++) send(16'(k), 16'(-k));
    bus.in_valid = 1'b1;
    bus.in_re    = 16'(NP - 1);
    bus.in_im    = 16'(-(NP - 1));
    @(negedge clk);
    check_val("last_accept_ready", 64'(bus.in_ready), 64'd1);
    check_val("pre_latency_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_val("latency_valid", 64'(bus.out_valid), 64'd1);
    check_val("first_bin_re", 64'(bus.out_re), 64'd0);
    drain();

    // Streaming: four back-to-back frames, no bubbles on either side
    stall_cnt = 0;
    fork
      begin
        for (int k = 0; k < 4 * NP; k++) send(16'(k * 3 + 1), 16'(k) ^ 16'h5a5a);
      end
      begin
        int t;
        int bad;
        t   = 0;
        bad = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 200) begin
          t++;
          @(negedge clk);
        end
        check_val("stream_start", 64'(t < 200), 64'd1);
        for (int i = 0; i < 4 * NP - 1; i++) begin
          @(negedge clk);
          if (!bus.out_valid) bad++;
        end
        check_val("stream_out_valid_gaps", 64'(bad), 64'd0);
      end
    join
    check_val("stream_in_stalls", 64'(stall_cnt), 64'd0);
    drain();

    // Backpressure: two frames fill both banks, 33rd sample must be refused
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2 * NP; k++) send(16'(16'h1000 + k), 16'(16'h2000 - k));
    bus.in_valid = 1'b1;
    bus.in_re    = 16'hdead;
    bus.in_im    = 16'hbeef;
    @(negedge clk);
    check_val("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check_val("bp_out_valid", 64'(bus.out_valid), 64'd1);
    begin
      logic [2*DW:0] held;
      held = {bus.out_last, bus.out_re, bus.out_im};
      check_val("bp_first_bin", 64'(bus.out_re), 64'h1000);
      repeat (5) begin
        @(negedge clk);
        check_val("bp_stable", 64'({bus.out_last, bus.out_re, bus.out_im}), 64'(held));
        check_val("bp_in_ready_held", 64'(bus.in_ready), 64'd0);
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();
    @(negedge clk);
    check_val("bp_no_extra_frame", 64'(bus.out_valid), 64'd0);
    check_val("bp_ready_again", 64'(bus.in_ready), 64'd1);

    // Random stalls over ten frames
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 10 * NP; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(16'($urandom), 16'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Reset with one full frame and a 7-sample partial frame stored
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < NP + 7; k++) send(16'(16'h3000 + k), 16'(k));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("mid_rst_out_data", 64'({bus.out_last, bus.out_re, bus.out_im}), 64'd0);
    check_val("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_discard_full", 64'(bus.out_valid), 64'd0);
    check_val("rst_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < NP; k++) send(16'(16'h0200 + k), 16'(16'h0400 + k));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
